// File: rtl/rcu_clk_seq_pkg.sv
// Shared types for the RCU core-clock sequencer: state encoding and config width.
package rcu_clk_seq_pkg;

  localparam int unsigned RCU_CLK_CFG_WIDTH = 3;

  typedef enum logic [3:0] {
    BYPASS,
    GATE_A,
    PROG,
    LOCK,
    SETTLE,
    SW_ON,
    RUN,
    GATE_B,
    SW_OFF,
    FAIL
  } rcu_clk_state_e;

endpackage

// File: rtl/rcu_sync2.sv
// Two-flop synchronizer with synchronous active-low reset to 0.
module rcu_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/rcu_clk_seq.sv
// Core PLL bring-up/tear-down sequencer with glitch-free bypass/PLL clock mux switching.
module rcu_clk_seq
  import rcu_clk_seq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         pll_en_i,
  input  logic [RCU_CLK_CFG_WIDTH-1:0] clk_cfg_i,
  input  logic                         pll_lock_i,
  output logic [RCU_CLK_CFG_WIDTH-1:0] pll_cfg_o,
  output logic                         pll_pd_o,
  output logic                         clk_sel_o,
  output logic                         clk_gate_en_o,
  output logic                         busy_o,
  output logic                         cfg_done_o,
  output logic                         timeout_o
);

  localparam logic [CNT_WIDTH-1:0] GATE_LOAD   = CNT_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LOAD   = CNT_WIDTH'(LOCK_TIMEOUT - 1);

  rcu_clk_state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           repwr_q, repwr_d;
  logic                           lock_s;
  logic                           req, cfg_chg, cnt_zero;
  logic [RCU_CLK_CFG_WIDTH-1:0]   pll_cfg_d;
  logic                           pd_d, sel_d, gate_d, busy_d, done_d, timeout_d;

  rcu_sync2 u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_lock_i),
    .q_o     (lock_s)
  );

  assign req      = pll_en_i & ~timeout_o;
  assign cfg_chg  = (clk_cfg_i != pll_cfg_o);
  assign cnt_zero = (cnt_q == '0);

  // Next state; repwr_d marks the one-cycle PLL power-down that precedes a relock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - CNT_WIDTH'(1);
    repwr_d = 1'b0;
    case (state_q)
      BYPASS: begin
        if (req) begin
          state_d = GATE_A;
          cnt_d   = GATE_LOAD;
        end
      end
      GATE_A: begin
        if (!pll_en_i)     state_d = BYPASS;
        else if (cnt_zero) state_d = PROG;
      end
      PROG: begin
        if (!pll_en_i) begin
          state_d = BYPASS;
        end else if (!repwr_q) begin
          state_d = LOCK;
          cnt_d   = LOCK_LOAD;
        end
      end
      LOCK: begin
        if (!pll_en_i) begin
          state_d = BYPASS;
        end else if (cfg_chg) begin
          state_d = PROG;
          repwr_d = 1'b1;
        end else if (lock_s) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_zero) begin
          state_d = FAIL;
        end
      end
      SETTLE: begin
        if (!pll_en_i) begin
          state_d = BYPASS;
        end else if (cfg_chg) begin
          state_d = PROG;
          repwr_d = 1'b1;
        end else if (!lock_s) begin
          state_d = LOCK;
          cnt_d   = LOCK_LOAD;
        end else if (cnt_zero) begin
          state_d = SW_ON;
          cnt_d   = GATE_LOAD;
        end
      end
      SW_ON: begin
        if (cnt_zero) begin
          state_d = pll_en_i ? RUN : GATE_B;
          cnt_d   = GATE_LOAD;
        end
      end
      RUN: begin
        if (!pll_en_i || cfg_chg || !lock_s) begin
          state_d = GATE_B;
          cnt_d   = GATE_LOAD;
        end
      end
      GATE_B: begin
        if (cnt_zero) begin
          state_d = SW_OFF;
          cnt_d   = GATE_LOAD;
        end
      end
      SW_OFF: begin
        if (cnt_zero) begin
          if (req) begin
            state_d = PROG;
            repwr_d = 1'b1;
          end else begin
            state_d = BYPASS;
          end
        end
      end
      FAIL:    state_d = BYPASS;
      default: state_d = BYPASS;
    endcase
  end

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    pd_d   = 1'b1;
    sel_d  = 1'b0;
    gate_d = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      BYPASS: begin
        gate_d = 1'b1;
        busy_d = 1'b0;
      end
      PROG:           pd_d = repwr_d;
      LOCK, SETTLE:   pd_d = 1'b0;
      SW_ON, GATE_B: begin
        pd_d  = 1'b0;
        sel_d = 1'b1;
      end
      RUN: begin
        pd_d   = 1'b0;
        sel_d  = 1'b1;
        gate_d = 1'b1;
        busy_d = 1'b0;
      end
      SW_OFF:  pd_d = 1'b0;
      FAIL:    gate_d = 1'b1;
      default: pd_d = 1'b1;
    endcase
    pll_cfg_d = (state_d == PROG && !repwr_d) ? clk_cfg_i : pll_cfg_o;
    done_d    = (state_d == RUN) && (state_q != RUN);
    timeout_d = pll_en_i & (timeout_o | (state_d == FAIL));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= BYPASS;
      cnt_q         <= '0;
      repwr_q       <= 1'b0;
      pll_cfg_o     <= '0;
      pll_pd_o      <= 1'b1;
      clk_sel_o     <= 1'b0;
      clk_gate_en_o <= 1'b1;
      busy_o        <= 1'b0;
      cfg_done_o    <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      repwr_q       <= repwr_d;
      pll_cfg_o     <= pll_cfg_d;
      pll_pd_o      <= pd_d;
      clk_sel_o     <= sel_d;
      clk_gate_en_o <= gate_d;
      busy_o        <= busy_d;
      cfg_done_o    <= done_d;
      timeout_o     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rcu_clk_seq.sv
// Scenario bench for rcu_clk_seq: expected event spacing derived from the sequencing rules.
module tb_rcu_clk_seq;

  localparam int GATE   = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int S_PD = 0, S_SEL = 1, S_GATE = 2, S_BUSY = 3;
  localparam logic [8:0] RST_VEC = 9'b000_1_0_1_0_0_0;

  logic       clk = 1'b0;
  logic       rst_n, pll_en, pll_lock;
  logic [2:0] clk_cfg, pll_cfg;
  logic       pd, sel, gate, busy, cfg_done, timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rst_seen = 1'b0;
  logic prev_sel = 1'b0, prev_gate = 1'b0, prev_done = 1'b0;

  rcu_clk_seq #(
    .GATE_CYCLES   (GATE),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (TMO),
    .CNT_WIDTH     (16)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pll_en_i      (pll_en),
    .clk_cfg_i     (clk_cfg),
    .pll_lock_i    (pll_lock),
    .pll_cfg_o     (pll_cfg),
    .pll_pd_o      (pd),
    .clk_sel_o     (sel),
    .clk_gate_en_o (gate),
    .busy_o        (busy),
    .cfg_done_o    (cfg_done),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Glitch-free mux rule and single-cycle done pulse, checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_seen) begin
      if (sel !== prev_sel) begin
        checks++;
        if (gate !== 1'b0 || prev_gate !== 1'b0) begin
          errors++;
          $display("FAIL sel_glitch: sel %b->%b with gate prev/now %b/%b, want 0/0", prev_sel, sel, prev_gate, gate);
        end
      end
      if (cfg_done === 1'b1) begin
        checks++;
        if (prev_done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: prev_done %b busy %b, want 0 0", prev_done, busy);
        end
      end
    end
    prev_sel  = sel;
    prev_gate = gate;
    prev_done = cfg_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_val(input int sig);
    case (sig)
      S_PD:    return pd;
      S_SEL:   return sel;
      S_GATE:  return gate;
      default: return busy;
    endcase
  endfunction

  // Returns the edge index at which sig first equals val, or -1 if the budget expires.
  task automatic wait_until(input int sig, input logic val, input int max_c, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < max_c && edge_n < 0; i++) begin
      tick();
      if (sig_val(sig) === val) edge_n = cyc;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({pll_cfg, pd, sel, gate, busy, cfg_done, timeout} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vals: got %b want %b", {pll_cfg, pd, sel, gate, busy, cfg_done, timeout}, RST_VEC);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({pll_cfg, pd, sel, gate, busy, cfg_done, timeout} !== RST_VEC) begin
      errors++;
      $display("FAIL idle_vals: got %b want %b", {pll_cfg, pd, sel, gate, busy, cfg_done, timeout}, RST_VEC);
    end
  endtask

  task automatic test_bringup();
    logic [2:0] c;
    int t0, e_g, e_pd, e_sel, e_run, p, d;
    c = 3'($urandom_range(1, 7));
    d = $urandom_range(1, 40);
    pll_lock = 1'b0;
    clk_cfg  = c;
    pll_en   = 1'b1;
    t0 = cyc;
    wait_until(S_GATE, 1'b0, 8, e_g);
    checks++;
    if (e_g !== t0 + 1) begin errors++; $display("FAIL bringup_gate_off: edge %0d want %0d", e_g, t0 + 1); end
    wait_until(S_PD, 1'b0, 20, e_pd);
    checks++;
    if (e_pd - e_g !== GATE) begin errors++; $display("FAIL bringup_gate_len: got %0d want %0d", e_pd - e_g, GATE); end
    checks++;
    if (pll_cfg !== c) begin errors++; $display("FAIL bringup_cfg: got %0d want %0d", pll_cfg, c); end
    checks++;
    if ({sel, gate, busy} !== 3'b001) begin errors++; $display("FAIL bringup_prog_outs: got %b want 001", {sel, gate, busy}); end
    repeat (d) tick();
    pll_lock = 1'b1;
    p = cyc + 1;
    wait_until(S_SEL, 1'b1, 200, e_sel);
    checks++;
    if (e_sel - p !== 2 + SETTLE) begin errors++; $display("FAIL bringup_sel_delay: got %0d want %0d", e_sel - p, 2 + SETTLE); end
    wait_until(S_GATE, 1'b1, 20, e_run);
    checks++;
    if (e_run - e_sel !== GATE) begin errors++; $display("FAIL bringup_sw_on_len: got %0d want %0d", e_run - e_sel, GATE); end
    checks++;
    if ({cfg_done, busy, pd, timeout} !== 4'b1000) begin errors++; $display("FAIL bringup_run_entry: got %b want 1000", {cfg_done, busy, pd, timeout}); end
    tick();
    checks++;
    if ({cfg_done, gate, sel} !== 3'b011) begin errors++; $display("FAIL bringup_run_hold: got %b want 011", {cfg_done, gate, sel}); end
  endtask

  task automatic test_reconfig();
    logic [2:0] c2;
    int t0, e1, e2, e3, e4, e5, e6;
    c2 = clk_cfg ^ 3'($urandom_range(1, 7));
    t0 = cyc;
    clk_cfg = c2;
    wait_until(S_GATE, 1'b0, 8, e1);
    checks++;
    if (e1 !== t0 + 1 || sel !== 1'b1) begin errors++; $display("FAIL reconf_gate_off: edge %0d sel %b want %0d 1", e1, sel, t0 + 1); end
    wait_until(S_SEL, 1'b0, 20, e2);
    checks++;
    if (e2 - e1 !== GATE || {gate, pd} !== 2'b00) begin errors++; $display("FAIL reconf_gate_b: len %0d gate/pd %b want %0d 00", e2 - e1, {gate, pd}, GATE); end
    wait_until(S_PD, 1'b1, 20, e3);
    checks++;
    if (e3 - e2 !== GATE || {sel, gate, busy} !== 3'b001) begin errors++; $display("FAIL reconf_sw_off: len %0d outs %b want %0d 001", e3 - e2, {sel, gate, busy}, GATE); end
    wait_until(S_PD, 1'b0, 5, e4);
    checks++;
    if (e4 - e3 !== 1) begin errors++; $display("FAIL reconf_pd_pulse: got %0d want 1", e4 - e3); end
    checks++;
    if (pll_cfg !== c2) begin errors++; $display("FAIL reconf_cfg: got %0d want %0d", pll_cfg, c2); end
    wait_until(S_SEL, 1'b1, 200, e5);
    checks++;
    if (e5 - e4 !== 2 + SETTLE) begin errors++; $display("FAIL reconf_relock: got %0d want %0d", e5 - e4, 2 + SETTLE); end
    wait_until(S_GATE, 1'b1, 20, e6);
    checks++;
    if (e6 - e5 !== GATE || cfg_done !== 1'b1) begin errors++; $display("FAIL reconf_run: len %0d done %b want %0d 1", e6 - e5, cfg_done, GATE); end
  endtask

  task automatic test_abort_run();
    int t0, e1, e2, e3;
    t0 = cyc;
    pll_en = 1'b0;
    wait_until(S_GATE, 1'b0, 8, e1);
    checks++;
    if (e1 !== t0 + 1) begin errors++; $display("FAIL abort_run_gate: edge %0d want %0d", e1, t0 + 1); end
    wait_until(S_SEL, 1'b0, 20, e2);
    checks++;
    if (e2 - e1 !== GATE) begin errors++; $display("FAIL abort_run_gate_b: got %0d want %0d", e2 - e1, GATE); end
    wait_until(S_PD, 1'b1, 20, e3);
    checks++;
    if (e3 - e2 !== GATE || {gate, sel, busy, cfg_done} !== 4'b1000) begin
      errors++; $display("FAIL abort_run_bypass: len %0d outs %b want %0d 1000", e3 - e2, {gate, sel, busy, cfg_done}, GATE);
    end
  endtask

  task automatic test_timeout();
    int e_pd, e_f, n;
    bit bad;
    pll_lock = 1'b0;
    repeat (4) tick();
    clk_cfg = 3'($urandom_range(0, 7));
    pll_en  = 1'b1;
    wait_until(S_PD, 1'b0, 20, e_pd);
    wait_until(S_PD, 1'b1, 200, e_f);
    checks++;
    if (e_f - e_pd !== 1 + TMO) begin errors++; $display("FAIL timeout_len: got %0d want %0d", e_f - e_pd, 1 + TMO); end
    checks++;
    if ({timeout, gate, sel, busy} !== 4'b1101) begin errors++; $display("FAIL timeout_fail_outs: got %b want 1101", {timeout, gate, sel, busy}); end
    tick();
    checks++;
    if ({timeout, busy, gate} !== 3'b101) begin errors++; $display("FAIL timeout_bypass: got %b want 101", {timeout, busy, gate}); end
    n = $urandom_range(5, 30);
    bad = 1'b0;
    repeat (n) begin
      tick();
      if (gate !== 1'b1 || busy !== 1'b0 || pd !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL timeout_no_retry: restarted within %0d cycles, want idle", n); end
    pll_en = 1'b0;
    tick();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    pll_en = 1'b1;
    tick();
    checks++;
    if ({gate, busy, timeout} !== 3'b010) begin errors++; $display("FAIL timeout_restart: got %b want 010", {gate, busy, timeout}); end
    pll_en = 1'b0;
    tick();
    checks++;
    if ({gate, busy, pd} !== 3'b101) begin errors++; $display("FAIL abort_gate_a: got %b want 101", {gate, busy, pd}); end
  endtask

  task automatic test_abort_lock();
    int e_pd, k;
    clk_cfg = 3'($urandom_range(0, 7));
    pll_en  = 1'b1;
    wait_until(S_PD, 1'b0, 20, e_pd);
    k = $urandom_range(1, 50);
    repeat (k) tick();
    pll_en = 1'b0;
    tick();
    checks++;
    if ({pd, gate, sel, busy} !== 4'b1100) begin errors++; $display("FAIL abort_lock: got %b want 1100 after %0d lock cycles", {pd, gate, sel, busy}, k); end
  endtask

  task automatic test_lock_glitch();
    int e_pd, d, g, q, e, e2;
    clk_cfg = 3'($urandom_range(0, 7));
    pll_en  = 1'b1;
    wait_until(S_PD, 1'b0, 20, e_pd);
    d = $urandom_range(1, 30);
    repeat (d) tick();
    pll_lock = 1'b1;
    g = $urandom_range(2, 14);
    repeat (2 + g) tick();
    pll_lock = 1'b0;
    q = cyc + 1;
    tick();
    pll_lock = 1'b1;
    wait_until(S_SEL, 1'b1, 200, e);
    checks++;
    if (e - q !== 3 + SETTLE) begin errors++; $display("FAIL glitch_resettle: got %0d want %0d (settle offset %0d)", e - q, 3 + SETTLE, g); end
    wait_until(S_GATE, 1'b1, 20, e2);
    checks++;
    if (e2 - e !== GATE || cfg_done !== 1'b1) begin errors++; $display("FAIL glitch_run: len %0d done %b want %0d 1", e2 - e, cfg_done, GATE); end
  endtask

  task automatic test_reset_sw_on();
    int e, e_s, r;
    pll_en = 1'b0;
    wait_until(S_PD, 1'b1, 40, e);
    pll_en = 1'b1;
    wait_until(S_SEL, 1'b1, 100, e_s);
    r = $urandom_range(0, 2);
    repeat (r) tick();
    checks++;
    if ({sel, gate} !== 2'b10) begin errors++; $display("FAIL sw_on_reached: got %b want 10", {sel, gate}); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pll_cfg, pd, sel, gate, busy, cfg_done, timeout} !== RST_VEC) begin
      errors++; $display("FAIL reset_mid_sw_on: got %b want %b", {pll_cfg, pd, sel, gate, busy, cfg_done, timeout}, RST_VEC);
    end
    rst_n  = 1'b1;
    pll_en = 1'b0;
    tick();
    checks++;
    if ({busy, gate, sel} !== 3'b010) begin errors++; $display("FAIL post_reset_idle: got %b want 010", {busy, gate, sel}); end
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_en   = 1'b0;
    pll_lock = 1'b0;
    clk_cfg  = 3'd0;
    test_reset();
    test_bringup();
    test_reconfig();
    test_abort_run();
    test_timeout();
    test_abort_lock();
    test_lock_glitch();
    test_reset_sw_on();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
